// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS core: sequences lw, sw, R-type,
// beq, addi and j through FETCH/DECODE/execute/writeback states and drives
// the ALU function select, operand selects and datapath write enables.
module mips_multicycle_ctrl #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] RTYPEEX = 4'd6;
  localparam logic [3:0] RTYPEWB = 4'd7;
  localparam logic [3:0] BEQEX   = 4'd8;
  localparam logic [3:0] ADDIEX  = 4'd9;
  localparam logic [3:0] ADDIWB  = 4'd10;
  localparam logic [3:0] JEX     = 4'd11;
  localparam logic [3:0] HALT    = 4'd12;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Where an unsupported op/funct sends the machine.
  localparam logic [3:0] FAULT_NEXT = ILLEGAL_TRAP ? HALT : FETCH;

  logic [3:0] state_q, state_d;
  logic       pcwrite, branch;
  logic       irwrite_raw, memwrite_raw, regwrite_raw, done_raw, illegal_raw;

  // State register, cleared asynchronously to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic and output decode of the current state.
  always_comb begin
    state_d      = state_q;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    irwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    regwrite_raw = 1'b0;
    done_raw     = 1'b0;
    illegal_raw  = 1'b0;
    iord         = 1'b0;
    memtoreg     = 1'b0;
    regdst       = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    alucontrol   = 3'b010;
    case (state_q)
      FETCH: begin
        alusrcb     = 2'b01;
        irwrite_raw = 1'b1;
        pcwrite     = 1'b1;
        state_d     = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default: begin
            illegal_raw = 1'b1;
            state_d     = FAULT_NEXT;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
        state_d      = FETCH;
      end
      MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
        done_raw     = 1'b1;
        state_d      = FETCH;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        state_d = RTYPEWB;
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default: begin
            illegal_raw = 1'b1;
            state_d     = FAULT_NEXT;
          end
        endcase
      end
      RTYPEWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
        state_d      = FETCH;
      end
      BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        done_raw   = 1'b1;
        state_d    = FETCH;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
        state_d      = FETCH;
      end
      JEX: begin
        pcsrc    = 2'b10;
        pcwrite  = 1'b1;
        done_raw = 1'b1;
        state_d  = FETCH;
      end
      HALT: state_d = HALT;
      default: begin
        // Unreachable encodings recover to FETCH even when trapping.
        illegal_raw = 1'b1;
        state_d     = FETCH;
      end
    endcase
  end

  // Enables are gated by rst_n so they drop the instant reset asserts.
  assign pcen       = rst_n & (pcwrite | (branch & zero));
  assign irwrite    = rst_n & irwrite_raw;
  assign memwrite   = rst_n & memwrite_raw;
  assign regwrite   = rst_n & regwrite_raw;
  assign instr_done = rst_n & done_raw;
  assign illegal    = rst_n & illegal_raw;
  assign state      = state_q;

endmodule
